// File: rtl/bf8b_pkg.sv
// rtl/bf8b_pkg.sv - shared fetch FSM encoding and default widths for the prefetch queue
package bf8b_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 8;
    localparam int INST_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        DRAIN  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - synchronous instruction FIFO with registered head and flush
module inst_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Pops from an empty queue are ignored; a push into a full queue only lands alongside a pop
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_n = wr_ptr + {{(PTR_W-1){1'b0}}, do_push};
        rd_ptr_n = rd_ptr + {{(PTR_W-1){1'b0}}, do_pop};
    end

    // Entry storage; no reset needed since validity is carried by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointers and the registered head; the head takes the pushed word when it becomes the only entry
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            head_valid <= (wr_ptr_n != rd_ptr_n);
            if (do_push && (wr_ptr == rd_ptr_n)) begin
                head_data <= push_data;
            end else begin
                head_data <= store[rd_ptr_n[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// rtl/inst_prefetch.sv - instruction prefetch queue; INST_PREFETCH_STATS_EN adds stat_flush_cnt
module inst_prefetch
    import bf8b_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef INST_PREFETCH_STATS_EN
    output logic [7:0]        stat_flush_cnt,
`endif
    input  logic              inst_take
);

    localparam int DATA_W = INST_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] fpc_n;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] drain_pc;
    logic [ADDR_W-1:0] drain_pc_n;
    logic [7:0]        hi;
    logic [7:0]        hi_n;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_data;

    // Fetch state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, request outputs and datapath updates; a redirect overrides any push or pop
    always_comb begin
        state_n    = state;
        fpc_n      = fpc;
        addr_n     = mem_addr;
        drain_pc_n = drain_pc;
        hi_n       = hi;
        push       = 1'b0;
        pop        = inst_take && !redirect;
        mem_req    = (state != IDLE);
        case (state)
            IDLE: begin
                if (redirect) begin
                    fpc_n = redirect_pc;
                end else if (!fifo_full) begin
                    state_n = REQ_HI;
                    addr_n  = fpc;
                end
            end
            REQ_HI, REQ_LO: begin
                if (redirect) begin
                    if (mem_ready) begin
                        state_n = IDLE;
                        fpc_n   = redirect_pc;
                    end else begin
                        state_n    = DRAIN;
                        drain_pc_n = redirect_pc;
                    end
                end else if (mem_ready) begin
                    if (state == REQ_HI) begin
                        hi_n    = mem_data;
                        state_n = REQ_LO;
                        addr_n  = fpc + PC_ONE;
                    end else begin
                        push    = 1'b1;
                        fpc_n   = fpc + PC_TWO;
                        state_n = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    drain_pc_n = redirect_pc;
                end
                if (mem_ready) begin
                    state_n = IDLE;
                    fpc_n   = redirect ? redirect_pc : drain_pc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Fetch PC, request address, saved redirect target and high-byte latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc      <= '0;
            mem_addr <= '0;
            drain_pc <= '0;
            hi       <= '0;
        end else begin
            fpc      <= fpc_n;
            mem_addr <= addr_n;
            drain_pc <= drain_pc_n;
            hi       <= hi_n;
        end
    end

    inst_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_data  ({hi, mem_data, fpc}),
        .pop        (pop),
        .head_valid (inst_valid),
        .head_data  (head_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign inst_out = head_data[DATA_W-1:ADDR_W];
    assign inst_pc  = head_data[ADDR_W-1:0];

`ifdef INST_PREFETCH_STATS_EN
    logic       discard;
    logic [7:0] flush_cnt;

    // A redirect counts only when it throws away a queued entry or a byte fetch in progress
    assign discard = redirect && (!fifo_empty || state == REQ_HI || state == REQ_LO);

    // Saturating count of discarding redirects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (discard && flush_cnt != 8'hFF) begin
            flush_cnt <= flush_cnt + 8'd1;
        end
    end

    assign stat_flush_cnt = flush_cnt;
`endif

endmodule
